// File: rtl/bgu_pkg.sv
// Shared types for the BGU delayed-branch scheduler.
// Condition codes, halt encoding, queue entry and state types.
package bgu_pkg;

    localparam logic [2:0] NV = 3'd0;
    localparam logic [2:0] AL = 3'd1;
    localparam logic [2:0] EQ = 3'd2;
    localparam logic [2:0] NE = 3'd3;
    localparam logic [2:0] LT = 3'd4;
    localparam logic [2:0] LE = 3'd5;
    localparam logic [2:0] GT = 3'd6;
    localparam logic [2:0] GE = 3'd7;

    localparam logic [7:0] HALT_HEAD = 8'b001_00_111;

    typedef struct packed {
        logic [7:0] head;
        logic [7:0] dest;
        logic [2:0] cond;
    } dbr_entry_t;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        HALTED
    } sched_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator for delayed branches.
// Ports: cond (3b code), N/V/Z flags in; take out.
module branch_cond_eval
    import bgu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic       take
);

    logic w_lt;
    assign w_lt = N ^ V;

    always_comb begin
        take = 1'b0;
        unique case (cond)
            NV: take = 1'b0;
            AL: take = 1'b1;
            EQ: take = Z;
            NE: take = !Z;
            LT: take = w_lt;
            LE: take = w_lt | Z;
            GT: take = !(w_lt | Z);
            GE: take = !w_lt;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/delayed_branch_sched.sv
// Program-order queue and resolver for two-lane delayed branches.
// Ports: p0/p1 enqueue lanes, stage-3 flags in; redirect/flush/halt/status out.
module delayed_branch_sched
    import bgu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_enq,
    input  logic [7:0]       p0_head,
    input  logic [7:0]       p0_dest,
    input  logic [2:0]       p0_cond,
    input  logic             p1_enq,
    input  logic [7:0]       p1_head,
    input  logic [7:0]       p1_dest,
    input  logic [2:0]       p1_cond,
    input  logic             flags_valid,
    input  logic             N,
    input  logic             V,
    input  logic             Z,
    output logic             redirect,
    output logic [8:0]       redirect_pc,
    output logic             flush,
    output logic             do_delayed_B,
    output logic             halted,
    output logic [7:0]       halt_addr,
    output logic             full,
    output logic             overflow,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    sched_state_t     r_state;
    dbr_entry_t       r_q [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W:0]   r_cnt;
    logic [8:0]       r_pc;
    logic             r_halted;
    logic [7:0]       r_haddr;
    logic             r_ovf;
    logic             r_dly;

    dbr_entry_t       w_head;
    dbr_entry_t       w_e0;
    dbr_entry_t       w_e1;
    logic             w_take;
    logic             w_resolve;
    logic             w_is_halt;
    logic             w_hit;
    logic             w_redir;
    logic             w_halt;
    logic             w_run_enq;
    logic [PTR_W:0]   w_free;
    logic [PTR_W:0]   w_room1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_drop;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr1;

    assign w_head = r_q[r_rd];
    assign w_e0   = {p0_head, p0_dest, p0_cond};
    assign w_e1   = {p1_head, p1_dest, p1_cond};

    branch_cond_eval u_eval (
        .cond (w_head.cond),
        .N    (N),
        .V    (V),
        .Z    (Z),
        .take (w_take)
    );

    assign w_resolve = (r_state == RUN) && (r_cnt != '0) && flags_valid;
    assign w_is_halt = (w_head.head == HALT_HEAD) && (w_head.cond == AL);
    assign w_hit     = w_resolve && w_take;
    assign w_redir   = w_hit && !w_is_halt;
    assign w_halt    = w_hit && w_is_halt;
    assign w_pop     = w_resolve && !w_take;

    // Space is judged on occupancy before this cycle's pop, so a
    // popping slot is not reused by a same-cycle enqueue.
    assign w_free    = DEPTH_C - r_cnt;
    assign w_room1   = w_free - (PTR_W+1)'(w_acc0);
    assign w_run_enq = (r_state == RUN) && !w_hit;
    assign w_acc0    = w_run_enq && p0_enq && (w_free != '0);
    assign w_acc1    = w_run_enq && p1_enq && (w_room1 != '0);
    assign w_drop    = w_run_enq &&
                       ((p0_enq && !w_acc0) || (p1_enq && !w_acc1));
    // p1 lands behind p0 when both are accepted, else in the next slot.
    assign w_wr1     = r_wr + PTR_W'(w_acc0);

    assign redirect     = w_redir;
    assign flush        = w_redir;
    assign redirect_pc  = w_redir ? {1'b0, w_head.dest} : r_pc;
    assign do_delayed_B = r_dly;
    assign halted       = r_halted;
    assign halt_addr    = r_haddr;
    assign full         = w_free < (PTR_W+1)'(2);
    assign overflow     = r_ovf;
    assign count        = r_cnt;

    always_ff @(posedge clk) begin
        if (w_acc0) r_q[r_wr] <= w_e0;
        if (w_acc1) r_q[w_wr1] <= w_e1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_rd     <= '0;
            r_wr     <= '0;
            r_cnt    <= '0;
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_haddr  <= '0;
            r_ovf    <= 1'b0;
            r_dly    <= 1'b0;
        end else begin
            r_dly <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (w_redir) begin
                        r_pc    <= {1'b0, w_head.dest};
                        r_rd    <= '0;
                        r_wr    <= '0;
                        r_cnt   <= '0;
                        r_dly   <= 1'b1;
                        r_state <= FLUSH;
                    end else if (w_halt) begin
                        r_haddr  <= w_head.dest;
                        r_halted <= 1'b1;
                        r_rd     <= '0;
                        r_wr     <= '0;
                        r_cnt    <= '0;
                        r_state  <= HALTED;
                    end else begin
                        r_wr  <= r_wr + PTR_W'(w_acc0) + PTR_W'(w_acc1);
                        r_rd  <= r_rd + PTR_W'(w_pop);
                        r_cnt <= r_cnt + (PTR_W+1)'(w_acc0)
                                       + (PTR_W+1)'(w_acc1)
                                       - (PTR_W+1)'(w_pop);
                        if (w_drop) r_ovf <= 1'b1;
                    end
                end
                FLUSH:   r_state <= RUN;
                HALTED:  r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_delayed_branch_sched.sv
// Self-checking bench for delayed_branch_sched.
// Directed scenarios plus random traffic against a queue-based model.
module tb_delayed_branch_sched;
    import bgu_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk, rst;
    logic p0_enq, p1_enq, flags_valid, N, V, Z;
    logic [7:0] p0_head, p0_dest, p1_head, p1_dest;
    logic [2:0] p0_cond, p1_cond;
    logic redirect, flush, do_delayed_B, halted, full, overflow;
    logic [8:0] redirect_pc;
    logic [7:0] halt_addr;
    logic [PTR_W:0] count;

    int n_chk = 0;
    int n_fail = 0;

    delayed_branch_sched #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_enq(p0_enq), .p0_head(p0_head), .p0_dest(p0_dest), .p0_cond(p0_cond),
        .p1_enq(p1_enq), .p1_head(p1_head), .p1_dest(p1_dest), .p1_cond(p1_cond),
        .flags_valid(flags_valid), .N(N), .V(V), .Z(Z),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .do_delayed_B(do_delayed_B), .halted(halted), .halt_addr(halt_addr),
        .full(full), .overflow(overflow), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0=RUN 1=FLUSH 2=HALTED
    dbr_entry_t m_q[$];
    int m_state;
    logic [8:0] m_pc;
    logic m_halted, m_ovf;
    logic [7:0] m_haddr;

    function automatic bit cond_true(logic [2:0] c, bit n, bit v, bit z);
        bit lt;
        lt = (n != v);
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return lt;
            3'd5: return lt || z;
            3'd6: return !(lt || z);
            default: return !lt;
        endcase
    endfunction

    function automatic bit m_take();
        if (m_state != 0 || m_q.size() == 0 || !flags_valid) return 1'b0;
        return cond_true(m_q[0].cond, N, V, Z);
    endfunction

    function automatic bit m_is_halt();
        if (m_q.size() == 0) return 1'b0;
        return m_q[0].head == 8'h27 && m_q[0].cond == 3'd1;
    endfunction

    function automatic logic [25:0] m_outs();
        bit rd;
        logic [8:0] pc;
        int sz;
        rd = m_take() && !m_is_halt();
        pc = rd ? {1'b0, m_q[0].dest} : m_pc;
        sz = m_q.size();
        return {rd, rd, pc, m_state == 1, m_halted, m_haddr,
                (DEPTH - sz) < 2, m_ovf, 3'(sz)};
    endfunction

    function automatic logic [25:0] dut_outs();
        return {redirect, flush, redirect_pc, do_delayed_B, halted,
                halt_addr, full, overflow, count};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_state = 0;
        m_pc = '0;
        m_halted = 1'b0;
        m_ovf = 1'b0;
        m_haddr = '0;
    endtask

    task automatic model_step();
        bit tk, hl;
        int free;
        dbr_entry_t e0, e1;
        if (!rst) begin
            model_reset();
            return;
        end
        tk = m_take();
        hl = tk && m_is_halt();
        e0 = {p0_head, p0_dest, p0_cond};
        e1 = {p1_head, p1_dest, p1_cond};
        if (m_state == 2) begin
        end else if (m_state == 1) begin
            m_state = 0;
        end else if (tk && !hl) begin
            m_pc = {1'b0, m_q[0].dest};
            m_q.delete();
            m_state = 1;
        end else if (hl) begin
            m_haddr = m_q[0].dest;
            m_halted = 1'b1;
            m_q.delete();
            m_state = 2;
        end else begin
            free = DEPTH - m_q.size();
            if (m_q.size() > 0 && flags_valid) void'(m_q.pop_front());
            if (p0_enq) begin
                if (free > 0) begin m_q.push_back(e0); free--; end
                else m_ovf = 1'b1;
            end
            if (p1_enq) begin
                if (free > 0) begin m_q.push_back(e1); free--; end
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic drive(bit e0, logic [7:0] h0, logic [7:0] d0, logic [2:0] c0,
                         bit e1, logic [7:0] h1, logic [7:0] d1, logic [2:0] c1,
                         bit fv, bit n, bit v, bit z);
        p0_enq = e0; p0_head = h0; p0_dest = d0; p0_cond = c0;
        p1_enq = e1; p1_head = h1; p1_dest = d1; p1_cond = c1;
        flags_valid = fv; N = n; V = v; Z = z;
    endtask

    task automatic idle();
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        idle();
        repeat (3) tick();
        n_chk++;
        if (dut_outs() !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h want 0", dut_outs());
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (count !== 3'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_count: got count=%0d full=%b want 0/0", count, full);
        end
    endtask

    task automatic test_beq();
        drive(1, 8'h11, 8'h25, EQ, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 1);
        #1;
        n_chk++;
        if ({redirect, flush, redirect_pc} !== {1'b1, 1'b1, 9'h025}) begin
            n_fail++;
            $display("FAIL beq_redirect: got r=%b f=%b pc=%h want 1 1 025",
                     redirect, flush, redirect_pc);
        end
        tick();
        idle();
        #1;
        n_chk++;
        if ({do_delayed_B, count, redirect} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL beq_delayed: got dB=%b cnt=%0d r=%b want 1 0 0",
                     do_delayed_B, count, redirect);
        end
        tick();
        n_chk++;
        if (do_delayed_B !== 1'b0 || redirect_pc !== 9'h025) begin
            n_fail++;
            $display("FAIL beq_after: got dB=%b pc=%h want 0 025", do_delayed_B, redirect_pc);
        end
    endtask

    task automatic test_not_taken();
        drive(1, 8'h12, 8'h10, NE, 1, 8'h13, 8'h12, NV, 0, 0, 0, 0);
        tick();
        n_chk++;
        if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL nt_count2: got %0d want 2", count);
        end
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 1);
        for (int i = 1; i >= 0; i--) begin
            #1;
            n_chk++;
            if (redirect !== 1'b0) begin
                n_fail++;
                $display("FAIL nt_redirect: got %b want 0", redirect);
            end
            tick();
            n_chk++;
            if (count !== 3'(i)) begin
                n_fail++;
                $display("FAIL nt_count: got %0d want %0d", count, i);
            end
        end
        idle();
    endtask

    task automatic test_order_flush();
        drive(1, 8'h14, 8'h30, GT, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 1, 8'h15, 8'h40, AL, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 0);
        #1;
        n_chk++;
        if ({redirect, redirect_pc, count} !== {1'b1, 9'h030, 3'd2}) begin
            n_fail++;
            $display("FAIL order_redirect: got r=%b pc=%h cnt=%0d want 1 030 2",
                     redirect, redirect_pc, count);
        end
        tick();
        drive(1, 8'h16, 8'h55, AL, 1, 8'h17, 8'h56, AL, 1, 0, 0, 0);
        #1;
        n_chk++;
        if ({do_delayed_B, redirect} !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_cycle: got dB=%b r=%b want 1 0", do_delayed_B, redirect);
        end
        tick();
        idle();
        #1;
        n_chk++;
        if ({count, redirect_pc, overflow} !== {3'd0, 9'h030, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_ignored: got cnt=%0d pc=%h ovf=%b want 0 030 0",
                     count, redirect_pc, overflow);
        end
    endtask

    task automatic test_overflow();
        drive(1, 8'h20, 8'h61, AL, 1, 8'h21, 8'h62, EQ, 0, 0, 0, 0);
        tick();
        drive(1, 8'h22, 8'h63, NE, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
        tick();
        n_chk++;
        if ({count, full, overflow} !== {3'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL full3: got cnt=%0d full=%b ovf=%b want 3 1 0", count, full, overflow);
        end
        drive(1, 8'h23, 8'h64, GE, 1, 8'h24, 8'h65, LT, 0, 0, 0, 0);
        tick();
        idle();
        #1;
        n_chk++;
        if ({count, full, overflow} !== {3'd4, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow: got cnt=%0d full=%b ovf=%b want 4 1 1", count, full, overflow);
        end
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 0);
        #1;
        n_chk++;
        if ({redirect, redirect_pc} !== {1'b1, 9'h061}) begin
            n_fail++;
            $display("FAIL oldest_head: got r=%b pc=%h want 1 061", redirect, redirect_pc);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 8'h30, 8'h77, AL, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 0);
        tick();
        idle();
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (dut_outs() !== 26'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h want 0", dut_outs());
        end
        #1;
        rst = 1'b1;
        tick();
        drive(1, 8'h31, 8'h08, AL, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 0);
        #1;
        n_chk++;
        if ({redirect, redirect_pc} !== {1'b1, 9'h008}) begin
            n_fail++;
            $display("FAIL post_reset: got r=%b pc=%h want 1 008", redirect, redirect_pc);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_halt();
        drive(1, 8'h27, 8'h5A, AL, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 0);
        #1;
        n_chk++;
        if (redirect !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_resolve: got r=%b h=%b want 0 0", redirect, halted);
        end
        tick();
        n_chk++;
        if ({halted, halt_addr, count} !== {1'b1, 8'h5A, 3'd0}) begin
            n_fail++;
            $display("FAIL halt_state: got h=%b addr=%h cnt=%0d want 1 5a 0",
                     halted, halt_addr, count);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'h40, 8'($urandom), AL, 1, 8'h41, 8'h42, AL, 1, 0, 0, 0);
            #1;
            n_chk++;
            if ({redirect, count, halted, do_delayed_B} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL halt_absorb: got r=%b cnt=%0d h=%b dB=%b want 0 0 1 0",
                         redirect, count, halted, do_delayed_B);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        logic [25:0] exp_o;
        rst = 1'b0;
        model_reset();
        idle();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i % 97 == 96) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            drive($urandom_range(0, 1),
                  ($urandom_range(0, 39) == 0) ? 8'h27 : 8'($urandom),
                  8'($urandom), 3'($urandom),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 39) == 0) ? 8'h27 : 8'($urandom),
                  8'($urandom), 3'($urandom),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            #1;
            exp_o = m_outs();
            n_chk++;
            if (dut_outs() !== exp_o) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h want %h", i, dut_outs(), exp_o);
            end
            tick();
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_not_taken();
        test_order_flush();
        test_overflow();
        test_async_reset();
        test_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
